// File: rtl/williams_video_pkg.sv
// Shared types and helpers for the Williams RGBI video output stage.
package williams_video_pkg;

    localparam int DEF_CW    = 4;
    localparam int DEF_IW    = 4;
    localparam int LUT_DEPTH = 2**(DEF_CW + DEF_IW);

    // Load state of the runtime colour table.
    typedef enum logic [1:0] {
        LOAD_IDLE    = 2'd0,
        LOAD_LOADING = 2'd1,
        LOAD_VALID   = 2'd2
    } load_state_t;

    // Reverse bits [w-1:1] of a w-bit code, keep bit 0. Board wiring of R/B.
    function automatic logic [15:0] swap_upper_bits(input logic [15:0] c, input int w);
        logic [15:0] res;
        res = c;
        for (int k = 1; k < 16; k++) begin
            if (k < w) res[k] = c[w-k];
        end
        return res;
    endfunction

    // Left-align a pw-bit product into 8 bits; keep the top 8 bits if wider.
    function automatic logic [7:0] fallback_scale(input logic [31:0] prod, input int pw);
        logic [31:0] t;
        if (pw <= 8) t = prod << (8 - pw);
        else         t = prod >> (pw - 8);
        return 8'(t);
    endfunction

endpackage

// File: rtl/williams_lut_ram.sv
// Colour lookup RAM: one write port broadcast to three copies, one read port each.
module williams_lut_ram
    import williams_video_pkg::*;
#(
    parameter int DEPTH = LUT_DEPTH,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_r,
    input  logic [AW-1:0] i_raddr_g,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_r,
    output logic [DW-1:0] o_rdata_g,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_mem_r [DEPTH];
    logic [DW-1:0] r_mem_g [DEPTH];
    logic [DW-1:0] r_mem_b [DEPTH];

    // Write all copies; registered reads return old data on same-address collision.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem_r[i_waddr] <= i_wdata;
            r_mem_g[i_waddr] <= i_wdata;
            r_mem_b[i_waddr] <= i_wdata;
        end
        o_rdata_r <= r_mem_r[i_raddr_r];
        o_rdata_g <= r_mem_g[i_raddr_g];
        o_rdata_b <= r_mem_b[i_raddr_b];
    end

endmodule

// File: rtl/williams_rgbi_pipe.sv
// RGBI to 24-bit RGB output stage: 3-stage pipeline, reloadable LUT with
// arithmetic fallback, delayed timing and pixel clock-enable.
module williams_rgbi_pipe
    import williams_video_pkg::*;
#(
    parameter int CW        = 4,
    parameter int IW        = 4,
    parameter int DIV       = 8,
    parameter int LUT_INDEX = 1,
    parameter int SWAP_RB   = 1
) (
    input  logic          clk_video,
    input  logic          reset_n,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    input  logic [IW-1:0] i_in,
    input  logic          hblank_in,
    input  logic          vblank_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          dn_download,
    input  logic [15:0]   dn_index,
    input  logic          dn_wr,
    input  logic [24:0]   dn_addr,
    input  logic [7:0]    dn_data,
    output logic [23:0]   rgb_out,
    output logic          hblank_out,
    output logic          vblank_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          ce_pix,
    output logic          lut_valid,
    output load_state_t   dbg_load_state
);

    localparam int AW    = CW + IW;
    localparam int DEPTH = 2**AW;
    localparam int DCW   = (DIV > 2) ? $clog2(DIV) : 1;

    // Handshake: the download port has no ready; a byte is taken in the cycle
    // dn_wr is high if download/index/address qualify, otherwise silently dropped.

    // ---------------- load control ----------------
    load_state_t   r_state, w_state_nxt;
    logic [AW:0]   r_cnt, w_cnt_nxt;
    logic          r_dl_prev;
    logic          w_idx_hit, w_wr_ok, w_dl_rise, w_dl_fall;

    assign w_idx_hit = (dn_index == 16'(LUT_INDEX));
    assign w_wr_ok   = dn_download && dn_wr && w_idx_hit && (dn_addr < 25'(DEPTH));
    assign w_dl_rise = dn_download && !r_dl_prev && w_idx_hit;
    assign w_dl_fall = !dn_download && r_dl_prev;

    // Load FSM state, write counter and download edge history.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= LOAD_IDLE;
            r_cnt     <= '0;
            r_dl_prev <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dl_prev <= dn_download;
        end
    end

    // Next state: a new LUT download restarts loading from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_dl_rise) begin
            w_state_nxt = LOAD_LOADING;
            w_cnt_nxt   = '0;
        end else if (r_state == LOAD_LOADING) begin
            if (w_dl_fall) begin
                w_state_nxt = (r_cnt == (AW+1)'(DEPTH)) ? LOAD_VALID : LOAD_IDLE;
            end else if (w_wr_ok && (r_cnt != (AW+1)'(DEPTH))) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    assign lut_valid      = (r_state == LOAD_VALID);
    assign dbg_load_state = r_state;

    // ---------------- pixel clock-enable divider ----------------
    logic [DCW-1:0] r_div;

    // Free-running divider; raw enable is the zero phase.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n)                       r_div <= '0;
        else if (r_div == DCW'(DIV - 1))    r_div <= '0;
        else                                r_div <= r_div + 1'b1;
    end

    // ---------------- S1: input register and address ----------------
    logic [CW-1:0] w_r_sw, w_b_sw;
    logic [CW-1:0] r_s1_r, r_s1_g, r_s1_b;
    logic [IW-1:0] r_s1_i;
    logic [4:0]    r_s1_t;   // {hblank, vblank, hs, vs, ce}

    assign w_r_sw = (SWAP_RB != 0) ? CW'(swap_upper_bits(16'(r_in), CW)) : r_in;
    assign w_b_sw = (SWAP_RB != 0) ? CW'(swap_upper_bits(16'(b_in), CW)) : b_in;

    // Capture swapped colour codes, intensity and timing.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_r <= '0;
            r_s1_g <= '0;
            r_s1_b <= '0;
            r_s1_i <= '0;
            r_s1_t <= '0;
        end else begin
            r_s1_r <= w_r_sw;
            r_s1_g <= g_in;
            r_s1_b <= w_b_sw;
            r_s1_i <= i_in;
            r_s1_t <= {hblank_in, vblank_in, hs_in, vs_in, (r_div == '0)};
        end
    end

    // ---------------- S2: RAM read and fallback product ----------------
    logic [7:0]    w_ram_r, w_ram_g, w_ram_b;
    logic [AW-1:0] w_prod_r, w_prod_g, w_prod_b;
    logic [7:0]    r_s2_fb_r, r_s2_fb_g, r_s2_fb_b;
    logic          r_s2_izero;
    logic [4:0]    r_s2_t;

    williams_lut_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (8)
    ) u_lut_ram (
        .i_clk     (clk_video),
        .i_we      (w_wr_ok),
        .i_waddr   (dn_addr[AW-1:0]),
        .i_wdata   (dn_data),
        .i_raddr_r ({r_s1_r, r_s1_i}),
        .i_raddr_g ({r_s1_g, r_s1_i}),
        .i_raddr_b ({r_s1_b, r_s1_i}),
        .o_rdata_r (w_ram_r),
        .o_rdata_g (w_ram_g),
        .o_rdata_b (w_ram_b)
    );

    assign w_prod_r = AW'(r_s1_r) * AW'(r_s1_i);
    assign w_prod_g = AW'(r_s1_g) * AW'(r_s1_i);
    assign w_prod_b = AW'(r_s1_b) * AW'(r_s1_i);

    // Register the fallback colour alongside the RAM read.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_fb_r  <= '0;
            r_s2_fb_g  <= '0;
            r_s2_fb_b  <= '0;
            r_s2_izero <= 1'b1;
            r_s2_t     <= '0;
        end else begin
            r_s2_fb_r  <= fallback_scale(32'(w_prod_r), AW);
            r_s2_fb_g  <= fallback_scale(32'(w_prod_g), AW);
            r_s2_fb_b  <= fallback_scale(32'(w_prod_b), AW);
            r_s2_izero <= (r_s1_i == '0);
            r_s2_t     <= r_s1_t;
        end
    end

    // ---------------- S3: select and forcing ----------------
    // Pick LUT or fallback; zero intensity and blanking force black.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out    <= '0;
            hblank_out <= 1'b0;
            vblank_out <= 1'b0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            ce_pix     <= 1'b0;
        end else begin
            if (r_s2_t[4] || r_s2_t[3] || r_s2_izero) rgb_out <= '0;
            else if (lut_valid)                       rgb_out <= {w_ram_r, w_ram_g, w_ram_b};
            else                                      rgb_out <= {r_s2_fb_r, r_s2_fb_g, r_s2_fb_b};
            hblank_out <= r_s2_t[4];
            vblank_out <= r_s2_t[3];
            hs_out     <= r_s2_t[2];
            vs_out     <= r_s2_t[1];
            ce_pix     <= r_s2_t[0];
        end
    end

endmodule
